// File: rtl/udt_state_table.sv
// Multi-channel UDT connection state manager: per-channel lifecycle FSM,
// idle-expiration counters, and a coalescing round-robin notification stream.
module udt_state_table #(
  parameter int unsigned         CHANNELS    = 4,
  parameter int unsigned         CH_W        = 2,
  parameter logic [CHANNELS-1:0] CLIENT_MASK = '0,
  parameter int unsigned         EXP_LIMIT   = 16
) (
  input  logic                  core_clk,
  input  logic                  core_rst_n,
  input  logic                  evt_valid_i,
  output logic                  evt_ready_o,
  input  logic [CH_W-1:0]       evt_chan_i,
  input  logic [2:0]            evt_code_i,
  input  logic [CHANNELS-1:0]   rsp_i,
  input  logic                  tick_i,
  output logic [8*CHANNELS-1:0] udt_state_o,
  output logic                  err_o,
  output logic                  state_valid_o,
  input  logic                  state_ready_i,
  output logic [CH_W-1:0]       state_chan_o,
  output logic [7:0]            state_o
);

  localparam logic [7:0] LISTENING  = 8'h01;
  localparam logic [7:0] CONNECTING = 8'h02;
  localparam logic [7:0] CONNECTED  = 8'h04;
  localparam logic [7:0] CLOSING    = 8'h08;
  localparam logic [7:0] SHUTDOWN   = 8'h10;
  localparam logic [7:0] BROCKEN    = 8'h20;

  localparam logic [2:0] EV_OPEN       = 3'd0;
  localparam logic [2:0] EV_HS_REQ     = 3'd1;
  localparam logic [2:0] EV_HS_RSP     = 3'd2;
  localparam logic [2:0] EV_CLOSE      = 3'd3;
  localparam logic [2:0] EV_PEER_CLOSE = 3'd4;
  localparam logic [2:0] EV_CLOSE_DONE = 3'd5;
  localparam logic [2:0] EV_BREAK      = 3'd6;

  localparam logic [7:0]    EXP_CNT  = 8'(EXP_LIMIT);
  localparam logic [CH_W:0] CHAN_END = (CH_W+1)'(CHANNELS);

  logic                  accept;
  logic                  chan_ok;
  logic                  ev_legal;
  logic                  evt_hit;
  logic                  reject;
  logic                  sel_client;
  logic [7:0]            sel_state;
  logic [7:0]            ev_next;
  logic [8*CHANNELS-1:0] st_nxt;
  logic [CHANNELS-1:0]   changed;
  logic [7:0]            cnt_q   [CHANNELS];
  logic [7:0]            cnt_nxt [CHANNELS];
  logic [CHANNELS-1:0]   pend_q;
  logic [CHANNELS-1:0]   pend_nxt;
  logic [CH_W-1:0]       last_q;
  logic [CH_W-1:0]       lo_idx;
  logic [CH_W-1:0]       hi_idx;
  logic [CH_W-1:0]       gnt_idx;
  logic                  lo_hit;
  logic                  hi_hit;
  logic                  load;
  logic                  gnt_take;
  logic [7:0]            gnt_state;

  // Decode the incoming event against the addressed channel's current state.
  always_comb begin
    accept     = evt_valid_i & evt_ready_o;
    chan_ok    = ({1'b0, evt_chan_i} < CHAN_END);
    sel_state  = SHUTDOWN;
    sel_client = 1'b0;
    ev_legal   = 1'b0;
    ev_next    = SHUTDOWN;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      if (CH_W'(c) == evt_chan_i) begin
        sel_state  = udt_state_o[8*c +: 8];
        sel_client = CLIENT_MASK[c];
      end
    end
    case (evt_code_i)
      EV_OPEN: begin
        ev_legal = (sel_state == SHUTDOWN);
        ev_next  = sel_client ? CONNECTING : LISTENING;
      end
      EV_HS_REQ: begin
        ev_legal = (sel_state == LISTENING) && !sel_client;
        ev_next  = CONNECTED;
      end
      EV_HS_RSP: begin
        ev_legal = (sel_state == CONNECTING) && sel_client;
        ev_next  = CONNECTED;
      end
      EV_CLOSE: begin
        ev_legal = (sel_state == LISTENING) || (sel_state == CONNECTING) ||
                   (sel_state == CONNECTED);
        ev_next  = CLOSING;
      end
      EV_PEER_CLOSE: begin
        ev_legal = (sel_state == CONNECTED);
        ev_next  = CLOSING;
      end
      EV_CLOSE_DONE: begin
        ev_legal = (sel_state == CLOSING);
        ev_next  = SHUTDOWN;
      end
      EV_BREAK: begin
        ev_legal = (sel_state != SHUTDOWN);
        ev_next  = BROCKEN;
      end
      default: begin
        ev_legal = 1'b1;
        ev_next  = SHUTDOWN;
      end
    endcase
    evt_hit = accept & chan_ok;
    reject  = accept & (~chan_ok | ~ev_legal);
  end

  // Per-channel next state and expiration counter; an event on a channel masks its expiry.
  always_comb begin
    st_nxt  = udt_state_o;
    changed = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      if (evt_hit && (CH_W'(c) == evt_chan_i)) begin
        if (ev_legal) st_nxt[8*c +: 8] = ev_next;
      end else if ((udt_state_o[8*c +: 8] == CONNECTED) && (cnt_q[c] == EXP_CNT)) begin
        st_nxt[8*c +: 8] = BROCKEN;
      end
      changed[c] = (st_nxt[8*c +: 8] != udt_state_o[8*c +: 8]);
      if (changed[c] || (udt_state_o[8*c +: 8] != CONNECTED)) begin
        cnt_nxt[c] = '0;
      end else if (rsp_i[c]) begin
        cnt_nxt[c] = '0;
      end else if (tick_i && (cnt_q[c] != EXP_CNT)) begin
        cnt_nxt[c] = cnt_q[c] + 8'd1;
      end else begin
        cnt_nxt[c] = cnt_q[c];
      end
    end
  end

  // Round-robin pick of the next pending channel, starting after the last grant.
  always_comb begin
    load      = ~state_valid_o | state_ready_i;
    lo_hit    = 1'b0;
    hi_hit    = 1'b0;
    lo_idx    = '0;
    hi_idx    = '0;
    gnt_state = '0;
    for (int c = int'(CHANNELS) - 1; c >= 0; c--) begin
      if (pend_q[c]) begin
        lo_hit = 1'b1;
        lo_idx = CH_W'(c);
        if (CH_W'(c) > last_q) begin
          hi_hit = 1'b1;
          hi_idx = CH_W'(c);
        end
      end
    end
    gnt_idx  = hi_hit ? hi_idx : lo_idx;
    gnt_take = load & lo_hit;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      if (CH_W'(c) == gnt_idx) gnt_state = udt_state_o[8*c +: 8];
      pend_nxt[c] = (pend_q[c] & ~(gnt_take && (CH_W'(c) == gnt_idx))) | changed[c];
    end
  end

  // Channel states, counters, event handshake and error pulse.
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      udt_state_o <= {CHANNELS{SHUTDOWN}};
      evt_ready_o <= 1'b0;
      err_o       <= 1'b0;
      for (int c = 0; c < int'(CHANNELS); c++) cnt_q[c] <= '0;
    end else begin
      udt_state_o <= st_nxt;
      evt_ready_o <= 1'b1;
      err_o       <= reject;
      for (int c = 0; c < int'(CHANNELS); c++) cnt_q[c] <= cnt_nxt[c];
    end
  end

  // Pending flags and the notification output register.
  always_ff @(posedge core_clk or negedge core_rst_n) begin
    if (!core_rst_n) begin
      pend_q        <= '0;
      last_q        <= CH_W'(CHANNELS - 1);
      state_valid_o <= 1'b0;
      state_chan_o  <= '0;
      state_o       <= '0;
    end else begin
      pend_q <= pend_nxt;
      if (load) begin
        state_valid_o <= lo_hit;
        if (lo_hit) begin
          state_chan_o <= gnt_idx;
          state_o      <= gnt_state;
          last_q       <= gnt_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_udt_state_table.sv
// Bench for udt_state_table: directed lifecycle scenarios plus random traffic,
// checked every cycle against a behavioural model of the state table.
module tb_udt_state_table;

  localparam int NCH = 4;
  localparam int LIM = 3;

  logic        core_clk = 1'b0;
  logic        core_rst_n = 1'b1;
  logic        evt_valid_i = 1'b0;
  logic        evt_ready_o;
  logic [2:0]  evt_chan_i = '0;
  logic [2:0]  evt_code_i = '0;
  logic [3:0]  rsp_i = '0;
  logic        tick_i = 1'b0;
  logic [31:0] udt_state_o;
  logic        err_o;
  logic        state_valid_o;
  logic        state_ready_i = 1'b1;
  logic [2:0]  state_chan_o;
  logic [7:0]  state_o;

  udt_state_table #(
    .CHANNELS   (4),
    .CH_W       (3),
    .CLIENT_MASK(4'b0010),
    .EXP_LIMIT  (3)
  ) dut (
    .core_clk     (core_clk),
    .core_rst_n   (core_rst_n),
    .evt_valid_i  (evt_valid_i),
    .evt_ready_o  (evt_ready_o),
    .evt_chan_i   (evt_chan_i),
    .evt_code_i   (evt_code_i),
    .rsp_i        (rsp_i),
    .tick_i       (tick_i),
    .udt_state_o  (udt_state_o),
    .err_o        (err_o),
    .state_valid_o(state_valid_o),
    .state_ready_i(state_ready_i),
    .state_chan_o (state_chan_o),
    .state_o      (state_o)
  );

  always #5 core_clk = ~core_clk;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: states, idle counters, pending set, notification slot.
  logic [7:0] m_st [NCH];
  int         m_cnt [NCH];
  bit         m_pend [NCH];
  int         m_last;
  bit         m_valid;
  int         m_chan;
  logic [7:0] m_sout;
  bit         m_err;
  bit         m_ready;

  // Lifecycle table: returns {legal, next_state}.
  function automatic logic [8:0] trans(input logic [2:0] code, input logic [7:0] s, input bit cli);
    case (code)
      3'd0: return (s == 8'h10) ? {1'b1, (cli ? 8'h02 : 8'h01)} : 9'h0;
      3'd1: return (s == 8'h01 && !cli) ? 9'h104 : 9'h0;
      3'd2: return (s == 8'h02 && cli) ? 9'h104 : 9'h0;
      3'd3: return (s == 8'h01 || s == 8'h02 || s == 8'h04) ? 9'h108 : 9'h0;
      3'd4: return (s == 8'h04) ? 9'h108 : 9'h0;
      3'd5: return (s == 8'h08) ? 9'h110 : 9'h0;
      3'd6: return (s != 8'h10) ? 9'h120 : 9'h0;
      default: return 9'h110;
    endcase
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_st[c] = 8'h10; m_cnt[c] = 0; m_pend[c] = 1'b0;
    end
    m_last = NCH - 1; m_valid = 1'b0; m_chan = 0; m_sout = 8'h00;
    m_err = 1'b0; m_ready = 1'b0;
  endtask

  task automatic model_step();
    logic [7:0] nx [NCH];
    bit         hit [NCH];
    bit         err;
    logic [8:0] r;
    int         ch;
    int         g;
    err = 1'b0;
    for (int c = 0; c < NCH; c++) begin nx[c] = m_st[c]; hit[c] = 1'b0; end
    if (evt_valid_i && m_ready) begin
      ch = int'(evt_chan_i);
      if (ch >= NCH) err = 1'b1;
      else begin
        hit[ch] = 1'b1;
        r = trans(evt_code_i, m_st[ch], (ch == 1));
        if (r[8]) nx[ch] = r[7:0];
        else err = 1'b1;
      end
    end
    for (int c = 0; c < NCH; c++)
      if (!hit[c] && m_st[c] == 8'h04 && m_cnt[c] == LIM) nx[c] = 8'h20;
    for (int c = 0; c < NCH; c++) begin
      if (nx[c] != m_st[c] || m_st[c] != 8'h04) m_cnt[c] = 0;
      else if (rsp_i[c]) m_cnt[c] = 0;
      else if (tick_i && m_cnt[c] < LIM) m_cnt[c]++;
    end
    if (!m_valid || state_ready_i) begin
      g = -1;
      for (int k = 1; k <= NCH; k++)
        if (g < 0 && m_pend[(m_last + k) % NCH]) g = (m_last + k) % NCH;
      if (g >= 0) begin
        m_valid = 1'b1; m_chan = g; m_sout = m_st[g]; m_last = g; m_pend[g] = 1'b0;
      end else m_valid = 1'b0;
    end
    for (int c = 0; c < NCH; c++) begin
      if (nx[c] != m_st[c]) m_pend[c] = 1'b1;
      m_st[c] = nx[c];
    end
    m_err = err;
    m_ready = 1'b1;
  endtask

  initial forever begin
    @(posedge core_clk or negedge core_rst_n);
    if (!core_rst_n) model_reset();
    else model_step();
  end

  // Notification log and stall tracking.
  typedef struct { int ch; logic [7:0] st; int cy; } note_t;
  note_t      notes[$];
  bit         stall_prev = 1'b0;
  logic [2:0] hold_chan;
  logic [7:0] hold_st;

  initial forever begin
    @(posedge core_clk or negedge core_rst_n);
    if (!core_rst_n) stall_prev = 1'b0;
    else begin
      if (state_valid_o && state_ready_i)
        notes.push_back('{int'(state_chan_o), state_o, cyc});
      stall_prev = state_valid_o && !state_ready_i;
      hold_chan  = state_chan_o;
      hold_st    = state_o;
    end
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge core_clk);
    cyc++;
    if (checking) begin
      chk("udt_state", udt_state_o, {m_st[3], m_st[2], m_st[1], m_st[0]});
      chk("evt_ready", 32'(evt_ready_o), 32'(m_ready));
      chk("err", 32'(err_o), 32'(m_err));
      chk("state_valid", 32'(state_valid_o), 32'(m_valid));
      if (m_valid) begin
        chk("state_chan", 32'(state_chan_o), 32'(m_chan));
        chk("state", 32'(state_o), 32'(m_sout));
      end
      if (stall_prev && core_rst_n) begin
        chk("hold_valid", 32'(state_valid_o), 32'h1);
        chk("hold_chan", 32'(state_chan_o), 32'(hold_chan));
        chk("hold_state", 32'(state_o), 32'(hold_st));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge core_clk);
  endtask

  task automatic send(input int ch, input int code);
    evt_valid_i = 1'b1;
    evt_chan_i  = 3'(ch);
    evt_code_i  = 3'(code);
    @(negedge core_clk);
    evt_valid_i = 1'b0;
  endtask

  task automatic ticks(input int n);
    tick_i = 1'b1;
    idle(n);
    tick_i = 1'b0;
  endtask

  initial begin
    model_reset();
    #2 core_rst_n = 1'b0;
    #1 checking = 1'b1;
    idle(2);
    chk("rst_udt", udt_state_o, 32'h10101010);
    chk("rst_ready", 32'(evt_ready_o), 32'h0);
    chk("rst_valid", 32'(state_valid_o), 32'h0);
    core_rst_n = 1'b1;
    idle(1);

    // Open a server and a client channel.
    notes.delete();
    send(0, 0);
    send(1, 0);
    chk("open_udt", udt_state_o, 32'h10100201);
    idle(4);
    chk("open_nnotes", 32'(notes.size()), 32'd2);
    if (notes.size() >= 2) begin
      chk("open_n0", {notes[0].st, 24'(notes[0].ch)}, {8'h01, 24'd0});
      chk("open_n1", {notes[1].st, 24'(notes[1].ch)}, {8'h02, 24'd1});
    end

    // Server lifecycle and an illegal event.
    send(0, 1); chk("ch0_conn", 32'(udt_state_o[7:0]), 32'h04);
    send(0, 3); chk("ch0_closing", 32'(udt_state_o[7:0]), 32'h08);
    send(0, 5); chk("ch0_shut", 32'(udt_state_o[7:0]), 32'h10);
    send(0, 0);
    send(0, 2);
    chk("illegal_err", 32'(err_o), 32'h1);
    chk("illegal_keep", 32'(udt_state_o[7:0]), 32'h01);
    idle(1);
    chk("err_one_cycle", 32'(err_o), 32'h0);

    // Expiry on ch2, then a response racing the final tick.
    send(2, 0); send(2, 1);
    ticks(3);
    chk("exp_not_yet", 32'(udt_state_o[23:16]), 32'h04);
    idle(1);
    chk("exp_broken", 32'(udt_state_o[23:16]), 32'h20);
    send(2, 7); send(2, 0); send(2, 1);
    ticks(2);
    tick_i = 1'b1; rsp_i = 4'b0100;
    idle(1);
    tick_i = 1'b0; rsp_i = 4'b0000;
    idle(3);
    chk("rsp_wins", 32'(udt_state_o[23:16]), 32'h04);

    // Stalled stream: ch3 changes coalesce behind an occupied slot.
    idle(6);
    state_ready_i = 1'b0;
    notes.delete();
    send(1, 7);
    idle(1);
    send(3, 0); send(3, 1); send(3, 3);
    idle(3);
    state_ready_i = 1'b1;
    idle(5);
    chk("stall_nnotes", 32'(notes.size()), 32'd2);
    if (notes.size() >= 2) begin
      chk("stall_n0", {notes[0].st, 24'(notes[0].ch)}, {8'h10, 24'd1});
      chk("stall_n1", {notes[1].st, 24'(notes[1].ch)}, {8'h08, 24'd3});
    end

    // Four channels break on the same edge.
    send(0, 1);
    send(1, 0); send(1, 2);
    send(3, 5); send(3, 0); send(3, 1);
    send(2, 7); send(2, 0); send(2, 1);
    chk("all_conn", udt_state_o, 32'h04040404);
    idle(6);
    notes.delete();
    ticks(3);
    idle(6);
    chk("all_broken", udt_state_o, 32'h20202020);
    chk("rr_nnotes", 32'(notes.size()), 32'd4);
    for (int i = 0; i < notes.size(); i++)
      chk("rr_state", 32'(notes[i].st), 32'h20);
    for (int i = 0; i + 1 < notes.size(); i++) begin
      chk("rr_order", 32'(notes[i+1].ch), 32'((notes[i].ch + 1) % NCH));
      chk("rr_b2b", 32'(notes[i+1].cy), 32'(notes[i].cy + 1));
    end

    // Out-of-range channel.
    send(5, 7);
    chk("oor_err", 32'(err_o), 32'h1);
    chk("oor_keep", udt_state_o, 32'h20202020);

    // Reset while a notification is outstanding.
    state_ready_i = 1'b0;
    send(0, 7);
    idle(2);
    chk("pre_rst_valid", 32'(state_valid_o), 32'h1);
    #1 core_rst_n = 1'b0;
    #1;
    chk("mid_rst_udt", udt_state_o, 32'h10101010);
    chk("mid_rst_out", {23'd0, evt_ready_o, err_o, state_valid_o, state_chan_o, state_o[1:0]},
        32'h0);
    chk("mid_rst_state", 32'(state_o), 32'h0);
    idle(2);
    core_rst_n = 1'b1;
    state_ready_i = 1'b1;
    idle(1);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      evt_valid_i   = ($urandom_range(0, 99) < 60);
      evt_chan_i    = 3'($urandom_range(0, 5));
      evt_code_i    = 3'($urandom_range(0, 7));
      tick_i        = ($urandom_range(0, 3) == 0);
      rsp_i         = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      state_ready_i = ($urandom_range(0, 3) != 0);
      @(negedge core_clk);
    end
    evt_valid_i = 1'b0; tick_i = 1'b0; rsp_i = '0; state_ready_i = 1'b1;
    idle(8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
